// File: rtl/bpsk_carrier_mapper.sv
// rtl/bpsk_carrier_mapper.sv - BPSK carrier sample mapper with 2-entry bit FIFO; define DIFF_ENC_EN for DBPSK encoding
module bpsk_carrier_mapper #(
  parameter int NUM            = 16,
  parameter int CYCLES_PER_BIT = 4,
  parameter int SAMPLE_W       = 8
) (
  input  logic                       clk_sig,
  input  logic                       reset_sig,
  input  logic [$clog2(NUM-1)-1:0]   counter_sig,
  input  logic                       bit_data_sig,
  input  logic                       bit_valid_sig,
  output logic                       bit_ready_sig,
  output logic signed [SAMPLE_W-1:0] sample_sig,
  output logic                       sample_valid_sig,
  output logic                       symbol_start_sig,
  output logic                       underrun_sig
);

  localparam int CW  = $clog2(NUM-1);
  localparam int CCW = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST_PH  = CW'(NUM-1);
  localparam logic [CCW-1:0] LAST_CYC = CCW'(CYCLES_PER_BIT-1);
  localparam logic [CW:0]    NUM_W    = (CW+1)'(NUM);
  localparam int             AMP      = (1 << (SAMPLE_W-1)) - 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Rounded sine value for table slot k (round half away from zero)
  function automatic logic signed [SAMPLE_W-1:0] lut_val(input int k);
    real x;
    int  v;
    x = real'(AMP) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(NUM));
    if (x >= 0.0) v = $rtoi(x + 0.5);
    else          v = -$rtoi(0.5 - x);
    return SAMPLE_W'(v);
  endfunction

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [1:0]                 r_cnt;
  logic                       r_q0;
  logic                       r_q1;
  logic [CCW-1:0]             r_cyc;
  logic                       r_cur_bit;
  logic                       r_fresh;
  logic                       r_undr_arm;
`ifdef DIFF_ENC_EN
  logic                       r_ref;
`endif

  logic signed [SAMPLE_W-1:0] w_lut [NUM];
  logic signed [SAMPLE_W-1:0] w_ph;
  logic signed [SAMPLE_W-1:0] w_sample_nxt;
  logic                       w_valid_nxt;
  logic                       w_start_nxt;
  logic                       w_wrap;
  logic                       w_nonempty;
  logic                       w_run_end;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_underrun_set;
  logic [1:0]                 w_cnt_pop;
  logic                       w_new_bit;

  for (genvar g = 0; g < NUM; g++) begin : g_lut
    assign w_lut[g] = lut_val(g);
  end

  // The last phase of a carrier period is the only place a bit may change
  assign w_wrap         = (counter_sig == LAST_PH);
  assign w_nonempty     = (r_cnt != 2'd0);
  assign w_run_end      = (r_state == S_RUN) && w_wrap && (r_cyc == LAST_CYC);
  assign w_pop          = w_nonempty && ((r_state == S_IDLE && w_wrap) || w_run_end);
  assign w_underrun_set = w_run_end && !w_nonempty;
  assign bit_ready_sig  = (r_cnt != 2'd2);
  assign w_push         = bit_valid_sig && bit_ready_sig;
  assign w_cnt_pop      = w_pop ? (r_cnt - 2'd1) : r_cnt;
`ifdef DIFF_ENC_EN
  assign w_new_bit      = r_ref ^ r_q0;
`else
  assign w_new_bit      = r_q0;
`endif

  // State register
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state: start on a boundary with data, stop when a symbol ends with nothing queued
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop)          w_state_nxt = S_RUN;
      S_RUN:   if (w_underrun_set) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: signed sine lookup for the current phase, zero while idle
  always_comb begin
    w_ph         = '0;
    w_sample_nxt = '0;
    w_valid_nxt  = 1'b0;
    w_start_nxt  = 1'b0;
    if ({1'b0, counter_sig} < NUM_W) w_ph = w_lut[counter_sig];
    if (r_state == S_RUN) begin
      w_sample_nxt = r_cur_bit ? w_ph : -w_ph;
      w_valid_nxt  = 1'b1;
      w_start_nxt  = r_fresh;
    end
  end

  // Two-entry FIFO, head in r_q0; a push never bypasses to the pop side
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      r_cnt <= 2'd0;
      r_q0  <= 1'b0;
      r_q1  <= 1'b0;
    end else begin
      if (w_pop) r_q0 <= r_q1;
      if (w_push) begin
        if (w_cnt_pop == 2'd0) r_q0 <= bit_data_sig;
        else                   r_q1 <= bit_data_sig;
      end
      r_cnt <= w_cnt_pop + {1'b0, w_push};
    end
  end

  // Symbol bookkeeping: carrier periods per bit, current polarity, one-shot flags
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      r_cyc      <= '0;
      r_cur_bit  <= 1'b0;
      r_fresh    <= 1'b0;
      r_undr_arm <= 1'b0;
`ifdef DIFF_ENC_EN
      r_ref      <= 1'b1;
`endif
    end else begin
      r_fresh    <= w_pop;
      r_undr_arm <= w_underrun_set;
      if (w_pop || r_state == S_IDLE) r_cyc <= '0;
      else if (w_wrap)                r_cyc <= (r_cyc == LAST_CYC) ? '0 : r_cyc + 1'b1;
      if (w_pop) r_cur_bit <= w_new_bit;
`ifdef DIFF_ENC_EN
      if (w_pop)               r_ref <= w_new_bit;
      else if (w_underrun_set) r_ref <= 1'b1;
`endif
    end
  end

  // Registered outputs, one cycle behind counter_sig
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      sample_sig       <= '0;
      sample_valid_sig <= 1'b0;
      symbol_start_sig <= 1'b0;
      underrun_sig     <= 1'b0;
    end else begin
      sample_sig       <= w_sample_nxt;
      sample_valid_sig <= w_valid_nxt;
      symbol_start_sig <= w_start_nxt;
      underrun_sig     <= r_undr_arm;
    end
  end

endmodule

// File: tb/tb_bpsk_carrier_mapper.sv
// tb/tb_bpsk_carrier_mapper.sv - randomized scoreboard bench for bpsk_carrier_mapper
module tb_bpsk_carrier_mapper;
  localparam int NUM = 16;
  localparam int CPB = 4;
  localparam int SW  = 8;
  localparam int CW  = 4;
  localparam int SPB = NUM * CPB;

  logic                 clk_sig = 1'b0;
  logic                 reset_sig = 1'b0;
  logic [CW-1:0]        counter_sig = '0;
  logic                 bit_data_sig = 1'b0;
  logic                 bit_valid_sig = 1'b0;
  logic                 bit_ready_sig;
  logic signed [SW-1:0] sample_sig;
  logic                 sample_valid_sig;
  logic                 symbol_start_sig;
  logic                 underrun_sig;

  int total = 0;
  int bad = 0;
  bit sb_q[$];
  int log_q[$];
  int mon_idx = 0;
  bit mon_pol = 1'b0;
  bit ref_m = 1'b1;
  int sampled_cnt = 0;
  bit cnt_run = 1'b1;
  int und_seen = 0;
  int sine[NUM];

  bpsk_carrier_mapper #(.NUM(NUM), .CYCLES_PER_BIT(CPB), .SAMPLE_W(SW)) dut (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .counter_sig(counter_sig),
    .bit_data_sig(bit_data_sig), .bit_valid_sig(bit_valid_sig), .bit_ready_sig(bit_ready_sig),
    .sample_sig(sample_sig), .sample_valid_sig(sample_valid_sig),
    .symbol_start_sig(symbol_start_sig), .underrun_sig(underrun_sig)
  );

  initial forever #5 clk_sig = ~clk_sig;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // upstream phase counter: record the value seen at the edge, then advance
  initial forever begin
    @(posedge clk_sig);
    sampled_cnt = int'(counter_sig);
    #1;
    if (cnt_run) counter_sig = (counter_sig == 4'd15) ? 4'd0 : counter_sig + 4'd1;
  end

  // monitor: expands queued bits into expected sample streams
  initial forever begin
    @(negedge clk_sig);
    if (reset_sig) begin
      if (underrun_sig) begin
        und_seen++;
        chk("underrun_at_bit_end", mon_idx, 0);
        chk("underrun_valid", int'(sample_valid_sig), 0);
        chk("underrun_sample", int'(sample_sig), 0);
`ifdef DIFF_ENC_EN
        ref_m = 1'b1;
`endif
      end
      if (sample_valid_sig) begin
        if (mon_idx == 0) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sample_without_bit: got sample %0d expected no output", int'(sample_sig));
          end else begin
            bit b;
            b = sb_q.pop_front();
`ifdef DIFF_ENC_EN
            ref_m = ref_m ^ b;
            mon_pol = ref_m;
`else
            mon_pol = b;
`endif
          end
        end
        chk("sample", int'(sample_sig), mon_pol ? sine[mon_idx % NUM] : -sine[mon_idx % NUM]);
        chk("symbol_start", int'(symbol_start_sig), int'(mon_idx == 0));
        chk("phase_align", sampled_cnt, mon_idx % NUM);
        log_q.push_back(int'(sample_sig));
        mon_idx = (mon_idx + 1) % SPB;
      end else begin
        chk("idle_sample", int'(sample_sig), 0);
        chk("idle_start", int'(symbol_start_sig), 0);
        chk("gap_mid_bit", mon_idx, 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sig);
      #2;
    end
  endtask

  task automatic send_bit(input bit b);
    int t;
    t = 0;
    bit_data_sig = b;
    bit_valid_sig = 1'b1;
    forever begin
      @(negedge clk_sig);
      if (bit_ready_sig) begin
        sb_q.push_back(b);
        break;
      end
      t++;
      if (t > 4 * SPB) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: got ready=0 expected ready within %0d cycles", 4 * SPB);
        break;
      end
    end
    step(1);
    bit_valid_sig = 1'b0;
  endtask

  task automatic wait_underrun(input int u0);
    int t;
    t = 0;
    while (und_seen == u0 && t < 6 * SPB) begin
      step(1);
      t++;
    end
    chk("underrun_seen", int'(und_seen > u0), 1);
  endtask

  task automatic do_reset(input int cycles);
    reset_sig = 1'b0;
    sb_q.delete();
    log_q.delete();
    mon_idx = 0;
    ref_m = 1'b1;
    step(cycles);
    reset_sig = 1'b1;
  endtask

  initial begin
    int u0;
    int acc;
    int t;
    for (int k = 0; k < NUM; k++) sine[k] = int'(127.0 * $sin(2.0 * 3.14159265358979 * k / NUM));

    // reset state
    step(3);
    chk("rst_sample", int'(sample_sig), 0);
    chk("rst_valid", int'(sample_valid_sig), 0);
    chk("rst_ready", int'(bit_ready_sig), 1);
    chk("rst_start", int'(symbol_start_sig), 0);
    chk("rst_underrun", int'(underrun_sig), 0);
    do_reset(0);
    step(5);

    // single bit 1: one symbol of +sine then a single underrun
    log_q.delete();
    u0 = und_seen;
    send_bit(1'b1);
    wait_underrun(u0);
    step(2);
    chk("single_len", log_q.size(), SPB);
    if (log_q.size() >= 13) begin
      chk("lut0", log_q[0], 0);
      chk("lut1", log_q[1], 49);
      chk("lut2", log_q[2], 90);
      chk("lut3", log_q[3], 117);
      chk("lut4", log_q[4], 127);
      chk("lut8", log_q[8], 0);
      chk("lut12", log_q[12], -127);
    end
    chk("single_underruns", und_seen - u0, 1);
    chk("idle_after_underrun", int'(sample_valid_sig), 0);

    // restart at an arbitrary phase, then back-to-back 1,0
    step($urandom_range(1, 20));
    log_q.delete();
    u0 = und_seen;
    send_bit(1'b1);
    send_bit(1'b0);
    wait_underrun(u0);
    step(2);
    chk("pair_len", log_q.size(), 2 * SPB);
    chk("pair_underruns", und_seen - u0, 1);
    if (log_q.size() == 2 * SPB) begin
      for (int i = 0; i < SPB; i += 5) chk("pair_negated", log_q[SPB + i], -log_q[i]);
    end

    // FIFO fill with the phase counter frozen away from the wrap value
    while (counter_sig == 4'd15) step(1);
    cnt_run = 1'b0;
    acc = 0;
    bit_valid_sig = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit_data_sig = 1'($urandom_range(0, 1));
      @(negedge clk_sig);
      if (bit_ready_sig) begin
        sb_q.push_back(bit_data_sig);
        acc++;
      end
      step(1);
    end
    bit_valid_sig = 1'b0;
    chk("fill_accepted", acc, 2);
    chk("fill_ready_low", int'(bit_ready_sig), 0);
    cnt_run = 1'b1;
    t = 0;
    while (!bit_ready_sig && t < NUM + 4) begin
      step(1);
      t++;
    end
    chk("ready_after_pop", int'(bit_ready_sig), 1);
    u0 = und_seen;
    wait_underrun(u0);

    // asynchronous reset in the middle of a symbol drops everything
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    step(NUM + 20);
    reset_sig = 1'b0;
    #1;
    chk("mid_rst_sample", int'(sample_sig), 0);
    chk("mid_rst_valid", int'(sample_valid_sig), 0);
    chk("mid_rst_ready", int'(bit_ready_sig), 1);
    chk("mid_rst_start", int'(symbol_start_sig), 0);
    do_reset(2);
    step(3 * NUM);
    chk("post_rst_idle", int'(sample_valid_sig), 0);

    // polarity sequence 1,1,0 (differential when enabled)
    u0 = und_seen;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    wait_underrun(u0);

    // randomized bits with occasional gaps that force underruns
    for (int n = 0; n < 60; n++) begin
      send_bit(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) step($urandom_range(0, 100));
    end
    u0 = und_seen;
    wait_underrun(u0);
    step(4);
    chk("drained_queue", sb_q.size(), 0);
    chk("drained_idx", mon_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
